// File: rtl/odd_issue_sched.sv
// odd_issue_sched -- issue scheduler for the SPU odd pipe.
//
// Decoded odd-pipe instructions enter through a valid/ready handshake into a
// 2-entry FIFO. The head issues (one per cycle) into the odd pipe unless a
// scoreboard of recently issued writers says one of its operands, or its own
// destination, is not yet forwardable. Branches are serialised: after a branch
// issues nothing else issues until the pipe resolves it; a taken branch spends
// one FLUSH cycle discarding everything queued.
//
// Optional feature macro: ODD_SCHED_STATS_EN adds the stall_count port.
//
// Ports
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready   decode handshake (accept on both high at the edge)
//   in_op_code            opcode, OPW bits
//   in_ra/rb/rt_addr      register addresses (7 bits each)
//   in_ra_used/rb_used    source operand is read
//   in_rt_wr              instruction writes rt
//   in_lat                issue-to-forwardable latency, 1..7 (0 acts as 1)
//   in_is_branch          instruction is a branch
//   br_resolve            odd pipe reports a branch outcome this cycle
//   branch_taken          outcome, meaningful only with br_resolve
//   iss_*                 registered instruction presented to the odd pipe
//   stall                 head valid but held by a hazard (combinational)
//   stall_count           saturating count of stall / branch-wait cycles
module odd_issue_sched #(
  parameter int OPW   = 8,
  parameter int DEPTH = 7
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [OPW-1:0] in_op_code,
  input  logic [6:0]     in_ra_addr,
  input  logic [6:0]     in_rb_addr,
  input  logic [6:0]     in_rt_addr,
  input  logic           in_ra_used,
  input  logic           in_rb_used,
  input  logic           in_rt_wr,
  input  logic [2:0]     in_lat,
  input  logic           in_is_branch,
  input  logic           br_resolve,
  input  logic           branch_taken,
  output logic           iss_valid,
  output logic [OPW-1:0] iss_op_code,
  output logic [6:0]     iss_ra_addr,
  output logic [6:0]     iss_rb_addr,
  output logic [6:0]     iss_rt_address,
  output logic           iss_wrt_en,
  output logic           stall
`ifdef ODD_SCHED_STATS_EN
  ,
  output logic [15:0]    stall_count
`endif
);

  typedef struct packed {
    logic [OPW-1:0] op;
    logic [6:0]     ra;
    logic [6:0]     rb;
    logic [6:0]     rt;
    logic           ra_used;
    logic           rb_used;
    logic           rt_wr;
    logic [2:0]     lat;
    logic           br;
  } ent_t;

  typedef enum logic [1:0] {ST_RUN, ST_STALL, ST_BR_WAIT, ST_FLUSH} state_t;

  // Remaining-cycles counters never go below zero.
  function automatic logic [2:0] f_rem_dec(input logic [2:0] rem);
    return (rem == 3'd0) ? 3'd0 : rem - 3'd1;
  endfunction

  // A latency of 0 behaves like 1, so both load a remaining count of 0.
  function automatic logic [2:0] f_lat_rem(input logic [2:0] lat);
    return (lat == 3'd0) ? 3'd0 : lat - 3'd1;
  endfunction

  state_t         r_state;
  logic [1:0]     r_count;
  ent_t           r_ent0;   // FIFO head
  ent_t           r_ent1;
  logic [DEPTH-1:0] r_sb_v;
  logic [6:0]     r_sb_rt  [DEPTH];
  logic [2:0]     r_sb_rem [DEPTH];

  logic           r_iss_valid;
  logic [OPW-1:0] r_iss_op;
  logic [6:0]     r_iss_ra;
  logic [6:0]     r_iss_rb;
  logic [6:0]     r_iss_rt;
  logic           r_iss_wr;

  ent_t w_in_ent;
  logic w_head_vld;
  logic w_hazard;
  logic w_issue;
  logic w_push;

  always_comb begin
    w_in_ent         = '0;
    w_in_ent.op      = in_op_code;
    w_in_ent.ra      = in_ra_addr;
    w_in_ent.rb      = in_rb_addr;
    w_in_ent.rt      = in_rt_addr;
    w_in_ent.ra_used = in_ra_used;
    w_in_ent.rb_used = in_rb_used;
    w_in_ent.rt_wr   = in_rt_wr;
    w_in_ent.lat     = in_lat;
    w_in_ent.br      = in_is_branch;
  end

  // A slot only blocks while its result is still in flight (rem > 0).
  always_comb begin
    w_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_sb_v[i] && (r_sb_rem[i] != 3'd0)) begin
        if ((r_ent0.ra_used && (r_sb_rt[i] == r_ent0.ra)) ||
            (r_ent0.rb_used && (r_sb_rt[i] == r_ent0.rb)) ||
            (r_ent0.rt_wr   && (r_sb_rt[i] == r_ent0.rt)))
          w_hazard = 1'b1;
      end
    end
  end

  assign w_head_vld = (r_count != 2'd0);
  assign stall      = w_head_vld && w_hazard;
  assign w_issue    = w_head_vld && !w_hazard &&
                      ((r_state == ST_RUN) || (r_state == ST_STALL));
  assign in_ready   = (r_count < 2'd2) && (r_state != ST_FLUSH);
  assign w_push     = in_valid && in_ready;

  // FIFO occupancy; the FLUSH cycle empties it (no push can happen then).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= 2'd0;
    end else if (r_state == ST_FLUSH) begin
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_issue})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO payload: entry 0 is always the head, entry 1 shifts down on a pop.
  always_ff @(posedge clock) begin
    if (w_issue)
      r_ent0 <= w_push ? w_in_ent : r_ent1;
    else if (w_push && (r_count == 2'd0))
      r_ent0 <= w_in_ent;
    if (w_push && !w_issue && (r_count == 2'd1))
      r_ent1 <= w_in_ent;
  end

  // Scoreboard: slot index is cycles since issue; slot 0 takes the new writer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      r_sb_v <= '0;
    else
      r_sb_v <= {r_sb_v[DEPTH-2:0], w_issue && r_ent0.rt_wr};
  end

  always_ff @(posedge clock) begin
    for (int i = DEPTH-1; i > 0; i--) begin
      r_sb_rt[i]  <= r_sb_rt[i-1];
      r_sb_rem[i] <= f_rem_dec(r_sb_rem[i-1]);
    end
    r_sb_rt[0]  <= r_ent0.rt;
    r_sb_rem[0] <= f_lat_rem(r_ent0.lat);
  end

  // Control FSM with registered issue outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_iss_valid <= 1'b0;
      r_iss_op    <= '0;
      r_iss_ra    <= '0;
      r_iss_rb    <= '0;
      r_iss_rt    <= '0;
      r_iss_wr    <= 1'b0;
    end else begin
      r_iss_valid <= w_issue;
      if (w_issue) begin
        r_iss_op <= r_ent0.op;
        r_iss_ra <= r_ent0.ra;
        r_iss_rb <= r_ent0.rb;
        r_iss_rt <= r_ent0.rt;
        r_iss_wr <= r_ent0.rt_wr;
      end
      case (r_state)
        ST_RUN, ST_STALL: begin
          if (w_issue && r_ent0.br)
            r_state <= ST_BR_WAIT;
          else if (stall)
            r_state <= ST_STALL;
          else
            r_state <= ST_RUN;
        end
        ST_BR_WAIT: begin
          if (br_resolve)
            r_state <= branch_taken ? ST_FLUSH : ST_RUN;
        end
        ST_FLUSH: r_state <= ST_RUN;
        default:  r_state <= ST_RUN;
      endcase
    end
  end

  assign iss_valid      = r_iss_valid;
  assign iss_op_code    = r_iss_op;
  assign iss_ra_addr    = r_iss_ra;
  assign iss_rb_addr    = r_iss_rb;
  assign iss_rt_address = r_iss_rt;
  assign iss_wrt_en     = r_iss_wr;

`ifdef ODD_SCHED_STATS_EN
  function automatic logic [15:0] f_sat_inc(input logic [15:0] cnt);
    return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  endfunction

  logic [15:0] r_stall_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      r_stall_count <= 16'd0;
    else if (stall || (r_state == ST_BR_WAIT))
      r_stall_count <= f_sat_inc(r_stall_count);
  end

  assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_odd_issue_sched.sv
module tb_odd_issue_sched;

  localparam logic [7:0] OP_SHLQBI = 8'h1B;
  localparam logic [7:0] OP_ROTQBY = 8'h1C;
  localparam logic [7:0] OP_GBB    = 8'h32;
  localparam logic [7:0] OP_BR     = 8'h40;
  localparam logic [7:0] OP_ALU    = 8'h21;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_op_code;
  logic [6:0] in_ra_addr, in_rb_addr, in_rt_addr;
  logic       in_ra_used, in_rb_used, in_rt_wr;
  logic [2:0] in_lat;
  logic       in_is_branch;
  logic       br_resolve, branch_taken;
  logic       iss_valid;
  logic [7:0] iss_op_code;
  logic [6:0] iss_ra_addr, iss_rb_addr, iss_rt_address;
  logic       iss_wrt_en;
  logic       stall;
`ifdef ODD_SCHED_STATS_EN
  logic [15:0] stall_count;
`endif

  always #5 clock = ~clock;

  odd_issue_sched #(.OPW(8), .DEPTH(7)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op_code(in_op_code),
    .in_ra_addr(in_ra_addr), .in_rb_addr(in_rb_addr), .in_rt_addr(in_rt_addr),
    .in_ra_used(in_ra_used), .in_rb_used(in_rb_used), .in_rt_wr(in_rt_wr),
    .in_lat(in_lat), .in_is_branch(in_is_branch),
    .br_resolve(br_resolve), .branch_taken(branch_taken),
    .iss_valid(iss_valid), .iss_op_code(iss_op_code),
    .iss_ra_addr(iss_ra_addr), .iss_rb_addr(iss_rb_addr),
    .iss_rt_address(iss_rt_address), .iss_wrt_en(iss_wrt_en),
    .stall(stall)
`ifdef ODD_SCHED_STATS_EN
    , .stall_count(stall_count)
`endif
  );

  typedef struct {
    logic [7:0] op;
    logic [6:0] ra, rb, rt;
    bit         rau, rbu, rtw;
    logic [2:0] lat;
    bit         br;
  } ins_t;

  typedef struct {
    bit         v;
    ins_t       ins;
    bit         res, tk;
    bit         e_rdy, e_stall, e_iv;
    logic [6:0] e_rt;
  } vec_t;

  int n_chk = 0;
  int n_pass = 0;

  // current drive values (seen by the reference model)
  bit   cur_v, cur_res, cur_tk;
  ins_t cur_ins;

  // reference model: in-order queue, spec state, per-register ready edge
  ins_t   mq[$];
  int     mmode;            // 0 RUN, 1 waiting on branch, 2 flushing
  longint rdy_at[128];
  longint medge;            // index of the upcoming clock edge
  bit     m_iv, m_rdy, m_stall, m_issue;
  ins_t   m_iss;
  int     m_cnt;

  function automatic ins_t mk(logic [7:0] op, logic [6:0] ra, logic [6:0] rb,
                              logic [6:0] rt, bit rau, bit rbu, bit rtw,
                              logic [2:0] lat, bit br);
    ins_t i;
    i.op = op; i.ra = ra; i.rb = rb; i.rt = rt;
    i.rau = rau; i.rbu = rbu; i.rtw = rtw; i.lat = lat; i.br = br;
    return i;
  endfunction

  function automatic vec_t row(bit v, ins_t i, bit res, bit tk,
                               bit rdy, bit st, bit iv, logic [6:0] rt);
    vec_t r;
    r.v = v; r.ins = i; r.res = res; r.tk = tk;
    r.e_rdy = rdy; r.e_stall = st; r.e_iv = iv; r.e_rt = rt;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input bit v, input ins_t i, input bit res, input bit tk);
    cur_v = v; cur_ins = i; cur_res = res; cur_tk = tk;
    in_valid = v; in_op_code = i.op;
    in_ra_addr = i.ra; in_rb_addr = i.rb; in_rt_addr = i.rt;
    in_ra_used = i.rau; in_rb_used = i.rbu; in_rt_wr = i.rtw;
    in_lat = i.lat; in_is_branch = i.br;
    br_resolve = res; branch_taken = tk;
  endtask

  task automatic model_reset();
    mq.delete();
    mmode = 0;
    for (int r = 0; r < 128; r++) rdy_at[r] = 0;
    medge = 0;
    m_iv = 0;
    m_iss = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    m_cnt = 0;
  endtask

  function automatic bit busy(logic [6:0] r);
    return rdy_at[r] > medge;
  endfunction

  task automatic model_comb();
    ins_t h;
    m_rdy = (mq.size() < 2) && (mmode != 2);
    m_stall = 0;
    if (mq.size() > 0) begin
      h = mq[0];
      m_stall = (h.rau && busy(h.ra)) || (h.rbu && busy(h.rb)) || (h.rtw && busy(h.rt));
    end
    m_issue = (mq.size() > 0) && !m_stall && (mmode == 0);
  endtask

  task automatic model_edge();
    ins_t h;
    int old_mode;
    old_mode = mmode;
    if ((m_stall || old_mode == 1) && m_cnt < 65535) m_cnt++;
    m_iv = m_issue;
    if (m_issue) begin
      h = mq.pop_front();
      m_iss = h;
      if (h.rtw) rdy_at[h.rt] = medge + ((h.lat == 0) ? 1 : h.lat);
      if (h.br) mmode = 1;
    end else if (old_mode == 1 && cur_res) begin
      mmode = cur_tk ? 2 : 0;
    end else if (old_mode == 2) begin
      mq.delete();
      mmode = 0;
    end
    if (cur_v && m_rdy) mq.push_back(cur_ins);
    medge++;
  endtask

  // one clock cycle, checked against the reference model
  task automatic tick();
    @(negedge clock);
    model_comb();
    chk("in_ready", in_ready, m_rdy);
    chk("stall", stall, m_stall);
    chk("iss_valid", iss_valid, m_iv);
    if (m_iv) begin
      chk("iss_op_code", iss_op_code, m_iss.op);
      chk("iss_ra_addr", iss_ra_addr, m_iss.ra);
      chk("iss_rb_addr", iss_rb_addr, m_iss.rb);
      chk("iss_rt_address", iss_rt_address, m_iss.rt);
      chk("iss_wrt_en", iss_wrt_en, m_iss.rtw);
    end
`ifdef ODD_SCHED_STATS_EN
    chk("stall_count", stall_count, m_cnt);
`endif
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    model_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[31];
    ins_t idle, a1, a2, a3, a4, p, c, b, x1, x2, x3;
    ins_t pp, cc, d1, d2, d3, f;
    int waited;

    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    a1 = mk(OP_SHLQBI, 10, 11, 1, 1, 1, 1, 4, 0);
    a2 = mk(OP_SHLQBI, 12, 13, 2, 1, 1, 1, 4, 0);
    a3 = mk(OP_SHLQBI, 14, 15, 3, 1, 1, 1, 4, 0);
    a4 = mk(OP_SHLQBI, 16, 17, 4, 1, 1, 1, 4, 0);
    p  = mk(OP_ROTQBY, 20, 21, 5, 1, 1, 1, 4, 0);
    c  = mk(OP_GBB,     5,  0, 6, 1, 0, 1, 2, 0);
    b  = mk(OP_BR,     30,  0, 0, 1, 0, 0, 1, 1);
    x1 = mk(OP_ALU, 0, 0, 40, 0, 0, 1, 1, 0);
    x2 = mk(OP_ALU, 0, 0, 41, 0, 0, 1, 1, 0);
    x3 = mk(OP_ALU, 0, 0, 42, 0, 0, 1, 1, 0);

    //             v  ins   res tk  rdy st iv rt
    tbl[0]  = row(1, a1,   0, 0,  1, 0, 0, 0);
    tbl[1]  = row(1, a2,   0, 0,  1, 0, 0, 0);
    tbl[2]  = row(1, a3,   0, 0,  1, 0, 1, 1);
    tbl[3]  = row(1, a4,   0, 0,  1, 0, 1, 2);
    tbl[4]  = row(0, idle, 0, 0,  1, 0, 1, 3);
    tbl[5]  = row(0, idle, 0, 0,  1, 0, 1, 4);
    tbl[6]  = row(0, idle, 0, 0,  1, 0, 0, 0);
    tbl[7]  = row(1, p,    0, 0,  1, 0, 0, 0);
    tbl[8]  = row(1, c,    0, 0,  1, 0, 0, 0);
    tbl[9]  = row(0, idle, 0, 0,  1, 1, 1, 5);
    tbl[10] = row(0, idle, 0, 0,  1, 1, 0, 0);
    tbl[11] = row(0, idle, 0, 0,  1, 1, 0, 0);
    tbl[12] = row(0, idle, 0, 0,  1, 0, 0, 0);
    tbl[13] = row(0, idle, 1, 1,  1, 0, 1, 6);
    tbl[14] = row(0, idle, 0, 0,  1, 0, 0, 0);
    tbl[15] = row(1, b,    0, 0,  1, 0, 0, 0);
    tbl[16] = row(1, x1,   0, 0,  1, 0, 0, 0);
    tbl[17] = row(1, x2,   0, 0,  1, 0, 1, 0);
    tbl[18] = row(0, idle, 1, 1,  0, 0, 0, 0);
    tbl[19] = row(1, x3,   0, 0,  0, 0, 0, 0);
    tbl[20] = row(0, idle, 0, 0,  1, 0, 0, 0);
    tbl[21] = row(0, idle, 0, 0,  1, 0, 0, 0);
    tbl[22] = row(0, idle, 0, 0,  1, 0, 0, 0);
    tbl[23] = row(1, b,    0, 0,  1, 0, 0, 0);
    tbl[24] = row(1, x1,   0, 0,  1, 0, 0, 0);
    tbl[25] = row(1, x2,   0, 0,  1, 0, 1, 0);
    tbl[26] = row(0, idle, 1, 0,  0, 0, 0, 0);
    tbl[27] = row(0, idle, 0, 0,  0, 0, 0, 0);
    tbl[28] = row(0, idle, 0, 0,  1, 0, 1, 40);
    tbl[29] = row(0, idle, 0, 0,  1, 0, 1, 41);
    tbl[30] = row(0, idle, 0, 0,  1, 0, 0, 0);

    // reset state
    do_reset();
    chk("rst_iss_valid", iss_valid, 0);
    chk("rst_iss_op", iss_op_code, 0);
    chk("rst_iss_ra", iss_ra_addr, 0);
    chk("rst_iss_rb", iss_rb_addr, 0);
    chk("rst_iss_rt", iss_rt_address, 0);
    chk("rst_iss_wr", iss_wrt_en, 0);
    chk("rst_stall", stall, 0);
    chk("rst_in_ready", in_ready, 1);
`ifdef ODD_SCHED_STATS_EN
    chk("rst_stall_count", stall_count, 0);
`endif

    // directed vectors: stream, RAW hazard, taken and not-taken branch
    for (int k = 0; k < 31; k++) begin
      drive(tbl[k].v, tbl[k].ins, tbl[k].res, tbl[k].tk);
      @(negedge clock);
      chk($sformatf("vec%0d_in_ready", k), in_ready, tbl[k].e_rdy);
      chk($sformatf("vec%0d_stall", k), stall, tbl[k].e_stall);
      chk($sformatf("vec%0d_iss_valid", k), iss_valid, tbl[k].e_iv);
      if (tbl[k].e_iv)
        chk($sformatf("vec%0d_iss_rt", k), iss_rt_address, tbl[k].e_rt);
      @(posedge clock);
      #1;
    end
`ifdef ODD_SCHED_STATS_EN
    chk("vec_stall_count", stall_count, 7);
`endif

    // backpressure behind a latency-7 hazard
    pp = mk(OP_ROTQBY, 0, 0, 50, 0, 0, 1, 7, 0);
    cc = mk(OP_GBB, 50, 0, 51, 1, 0, 1, 1, 0);
    d1 = mk(OP_ALU, 0, 0, 60, 0, 0, 1, 1, 0);
    d2 = mk(OP_ALU, 0, 0, 61, 0, 0, 1, 1, 0);
    d3 = mk(OP_ALU, 0, 0, 62, 0, 0, 1, 1, 0);
    do_reset();
    drive(1, pp, 0, 0); tick();
    drive(1, cc, 0, 0); tick();
    drive(1, d1, 0, 0); tick();
    drive(1, d2, 0, 0);
    chk("bp_full_in_ready", in_ready, 0);
    waited = 0;
    while (!in_ready && waited < 20) begin
      tick();
      waited++;
    end
    chk("bp_wait_cycles", waited, 6);
    chk("bp_consumer_valid", iss_valid, 1);
    chk("bp_consumer_rt", iss_rt_address, 51);
    tick();
    drive(1, d3, 0, 0); tick();
    drive(0, idle, 0, 0);
    repeat (5) tick();

    // reset pulsed while stalled
    do_reset();
    drive(1, pp, 0, 0); tick();
    drive(1, cc, 0, 0); tick();
    drive(0, idle, 0, 0); tick(); tick();
    chk("mid_pre_stall", stall, 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_iss_valid", iss_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_iss_rt", iss_rt_address, 0);
`ifdef ODD_SCHED_STATS_EN
    chk("mid_rst_stall_count", stall_count, 0);
`endif
    reset = 1'b0;
    model_reset();
    tick();
    f = mk(OP_SHLQBI, 50, 2, 3, 1, 1, 1, 1, 0);
    drive(1, f, 0, 0); tick();
    drive(0, idle, 0, 0); tick();
    chk("mid_fresh_valid", iss_valid, 1);
    chk("mid_fresh_rt", iss_rt_address, 3);
    tick();

    // randomized traffic against the reference model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      ins_t r;
      r = mk($urandom, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 7), ($urandom_range(0, 9) == 0));
      drive(($urandom_range(0, 3) != 0), r, ($urandom_range(0, 3) == 0), $urandom_range(0, 1));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
